gaussian_col_feeder: RTL and testbench



---
 rtl/gaussian_col_feeder_if.sv | 36 +++
 rtl/gaussian_col_feeder.sv | 158 +++++++++++++++
 tb/tb_gaussian_col_feeder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gaussian_col_feeder_if.sv
// Bus between a raster pixel source / 5x5 Gaussian filter and the column feeder.
// The master side supplies pixels and consumes columns; the feeder is the slave.
interface gaussian_col_feeder_if #(
  parameter int unsigned BIT_LENGTH = 5,
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned IMG_H      = 32
);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);

  logic                  start;
  logic [BIT_LENGTH-1:0] in_pixel;
  logic                  in_valid;
  logic                  in_ready;
  logic [BIT_LENGTH-1:0] col_pixel0;
  logic [BIT_LENGTH-1:0] col_pixel1;
  logic [BIT_LENGTH-1:0] col_pixel2;
  logic [BIT_LENGTH-1:0] col_pixel3;
  logic [BIT_LENGTH-1:0] col_pixel4;
  logic                  col_enable;
  logic [RW-1:0]         col_row;
  logic [CW-1:0]         col_idx;
  logic                  done;

  modport master (
    output start, in_pixel, in_valid,
    input  in_ready, col_pixel0, col_pixel1, col_pixel2, col_pixel3, col_pixel4,
    input  col_enable, col_row, col_idx, done
  );

  modport slave (
    input  start, in_pixel, in_valid,
    output in_ready, col_pixel0, col_pixel1, col_pixel2, col_pixel3, col_pixel4,
    output col_enable, col_row, col_idx, done
  );
endinterface

// File: rtl/gaussian_col_feeder.sv
// Frame buffer that loads one raster frame, then streams every 5-row band as
// back-to-back vertical 5-pixel columns with a single contiguous enable burst.
module gaussian_col_feeder #(
  parameter int unsigned BIT_LENGTH = 5,
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned IMG_H      = 32
) (
  input logic               clk,
  input logic               reset,
  gaussian_col_feeder_if.slave bus
);
  localparam int unsigned NumPix = IMG_W * IMG_H;
  localparam int unsigned AW     = $clog2(NumPix);
  localparam int unsigned RW     = $clog2(IMG_H);
  localparam int unsigned CW     = $clog2(IMG_W);

  localparam logic [AW-1:0] LastAddr = AW'(NumPix - 1);
  localparam logic [RW-1:0] LastRow  = RW'(IMG_H - 5);
  localparam logic [CW-1:0] LastCol  = CW'(IMG_W - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StStream = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  wr_en;

  logic [BIT_LENGTH-1:0] mem [NumPix];
  logic [AW-1:0]         rd_addr [5];

  logic [BIT_LENGTH-1:0] pix_q [5];
  logic [BIT_LENGTH-1:0] pix_d [5];
  logic                  en_q, en_d;
  logic                  done_q, done_d;
  logic [RW-1:0]         out_row_q, out_row_d;
  logic [CW-1:0]         out_col_q, out_col_d;

  // Word address of row (r+k), column c; r+4 never exceeds IMG_H-1 while streaming.
  always_comb begin
    for (int unsigned k = 0; k < 5; k++) begin
      rd_addr[k] = (AW'(row_q) + AW'(k)) * AW'(IMG_W) + AW'(col_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    row_d     = row_q;
    col_d     = col_q;
    wr_en     = 1'b0;
    pix_d     = pix_q;
    en_d      = en_q;
    done_d    = done_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;

    unique case (state_q)
      StIdle: begin
        wr_addr_d = '0;
        if (bus.start) begin
          state_d = StLoad;
        end
      end

      StLoad: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (wr_addr_q == LastAddr) begin
            wr_addr_d = '0;
            state_d   = StStream;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end

      StStream: begin
        for (int unsigned k = 0; k < 5; k++) begin
          pix_d[k] = mem[rd_addr[k]];
        end
        en_d      = 1'b1;
        out_row_d = row_q;
        out_col_d = col_q;
        if (col_q == LastCol) begin
          col_d = '0;
          if (row_q == LastRow) begin
            state_d = StDone;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      StDone: begin
        for (int unsigned k = 0; k < 5; k++) begin
          pix_d[k] = '0;
        end
        en_d      = 1'b0;
        done_d    = 1'b1;
        out_row_d = '0;
        out_col_d = '0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_addr_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
      for (int unsigned k = 0; k < 5; k++) begin
        pix_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      en_q      <= en_d;
      done_q    <= done_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
      pix_q     <= pix_d;
    end
  end

  // Frame storage is never cleared; a reset only abandons the partial frame.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr_q] <= bus.in_pixel;
    end
  end

  assign bus.in_ready   = (state_q == StLoad);
  assign bus.col_pixel0 = pix_q[0];
  assign bus.col_pixel1 = pix_q[1];
  assign bus.col_pixel2 = pix_q[2];
  assign bus.col_pixel3 = pix_q[3];
  assign bus.col_pixel4 = pix_q[4];
  assign bus.col_enable = en_q;
  assign bus.col_row    = out_row_q;
  assign bus.col_idx    = out_col_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_gaussian_col_feeder.sv
// Scoreboard bench: an 8x6 instance checked against a frame model, plus a 5x5 corner instance.
module tb_gaussian_col_feeder;
  localparam int W = 8;
  localparam int H = 6;
  localparam int NA = W * H;
  localparam int NCOL = W * (H - 4);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gaussian_col_feeder_if #(.BIT_LENGTH(5), .IMG_W(W), .IMG_H(H)) a_if ();
  gaussian_col_feeder_if #(.BIT_LENGTH(5), .IMG_W(5), .IMG_H(5)) b_if ();

  gaussian_col_feeder #(.BIT_LENGTH(5), .IMG_W(W), .IMG_H(H)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  gaussian_col_feeder #(.BIT_LENGTH(5), .IMG_W(5), .IMG_H(5)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  typedef struct {
    logic [24:0] pix;
    int          row;
    int          col;
  } col_t;

  col_t        exp_q[$];
  logic [4:0]  frame_a [NA];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every band top r, every column c, rows r..r+4 of the frame.
  task automatic push_exp_a();
    col_t e;
    for (int r = 0; r <= H - 5; r++) begin
      for (int c = 0; c < W; c++) begin
        e.pix = {frame_a[(r + 4) * W + c], frame_a[(r + 3) * W + c], frame_a[(r + 2) * W + c],
                 frame_a[(r + 1) * W + c], frame_a[r * W + c]};
        e.row = r;
        e.col = c;
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor for the 8x6 instance.
  int   run_a = 0;
  int   bursts_a = 0;
  logic prev_en_a = 1'b0;
  logic prev_done_a = 1'b0;
  always @(negedge clk) begin
    col_t e;
    if (reset) begin
      run_a = 0;
      bursts_a = 0;
      prev_en_a = 1'b0;
      prev_done_a = 1'b0;
    end else begin
      if (a_if.col_enable) begin
        if (!prev_en_a) bursts_a++;
        run_a++;
        chk("column_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("col_pixels", {a_if.col_pixel4, a_if.col_pixel3, a_if.col_pixel2,
                             a_if.col_pixel1, a_if.col_pixel0}, e.pix);
          chk("col_row", a_if.col_row, e.row);
          chk("col_idx", a_if.col_idx, e.col);
        end
      end
      if (a_if.done && !prev_done_a) begin
        chk("enable_falls_with_done", prev_en_a && !a_if.col_enable, 1);
        chk("burst_length", run_a, NCOL);
        chk("single_burst", bursts_a, 1);
      end
      if (prev_done_a) begin
        chk("done_sticky", a_if.done, 1);
        chk("enable_off_in_done", a_if.col_enable, 0);
      end
      prev_en_a = a_if.col_enable;
      prev_done_a = a_if.done;
    end
  end

  // Monitor for the 5x5 instance: all-31 frame.
  int   cnt_b = 0;
  logic prev_done_b = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      cnt_b = 0;
      prev_done_b = 1'b0;
    end else begin
      if (b_if.col_enable) begin
        cnt_b++;
        chk("b_pixels", {b_if.col_pixel4, b_if.col_pixel3, b_if.col_pixel2,
                         b_if.col_pixel1, b_if.col_pixel0}, 25'h1ff_ffff);
        chk("b_row", b_if.col_row, 0);
        chk("b_idx", b_if.col_idx, cnt_b - 1);
      end
      if (b_if.done && !prev_done_b) begin
        chk("b_enable_cycles", cnt_b, 5);
        chk("b_enable_off", b_if.col_enable, 0);
      end
      prev_done_b = b_if.done;
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_idle_a(input string tag);
    chk({tag, "_in_ready"}, a_if.in_ready, 0);
    chk({tag, "_col_enable"}, a_if.col_enable, 0);
    chk({tag, "_done"}, a_if.done, 0);
    chk({tag, "_pixels"}, {a_if.col_pixel4, a_if.col_pixel3, a_if.col_pixel2,
                           a_if.col_pixel1, a_if.col_pixel0}, 0);
    chk({tag, "_row_idx"}, {a_if.col_row, a_if.col_idx}, 0);
  endtask

  // Start together with a junk valid pixel: only start may act.
  task automatic start_a();
    a_if.start = 1'b1;
    a_if.in_valid = 1'b1;
    a_if.in_pixel = 5'd17;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    a_if.in_valid = 1'b0;
    chk("ready_in_load", a_if.in_ready, 1);
  endtask

  // mode 0: back-to-back, 1: valid pattern 1,0,0, 2: random gaps.
  task automatic load_a(input int mode, input int limit, output int ready_cyc);
    int   i = 0;
    int   cyc = 0;
    logic v;
    logic rdy;
    ready_cyc = 0;
    while (i < limit && cyc < 2000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      a_if.in_valid = v;
      a_if.in_pixel = frame_a[i];
      rdy = a_if.in_ready;
      if (rdy) ready_cyc++;
      @(posedge clk); #1;
      if (v && rdy) i++;
      cyc++;
    end
    a_if.in_valid = 1'b0;
    chk("load_complete", i, limit);
  endtask

  task automatic wait_done_a();
    int k = 0;
    while (!a_if.done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("done_reached", a_if.done, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic pattern_frame();
    for (int i = 0; i < NA; i++) frame_a[i] = 5'(i % 32);
  endtask

  initial begin
    int rc;
    int k;
    a_if.start = 1'b0;
    a_if.in_valid = 1'b0;
    a_if.in_pixel = '0;
    b_if.start = 1'b0;
    b_if.in_valid = 1'b0;
    b_if.in_pixel = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle_a("reset");

    // Back-to-back frame with explicit first-column latency check.
    pattern_frame();
    push_exp_a();
    start_a();
    load_a(0, NA, rc);
    chk("ready_cycles", rc, NA);
    chk("ready_drops_after_last", a_if.in_ready, 0);
    chk("no_column_yet", a_if.col_enable, 0);
    @(posedge clk); #1;
    chk("first_col_enable", a_if.col_enable, 1);
    chk("first_col_pixels", {a_if.col_pixel4, a_if.col_pixel3, a_if.col_pixel2,
                             a_if.col_pixel1, a_if.col_pixel0}, {5'd0, 5'd24, 5'd16, 5'd8, 5'd0});
    wait_done_a();

    // Same frame through a 1,0,0 valid pattern.
    pulse_reset();
    check_idle_a("reset2");
    push_exp_a();
    start_a();
    load_a(1, NA, rc);
    wait_done_a();

    // Abort after 20 pixels, then a full reload.
    pulse_reset();
    start_a();
    load_a(0, 20, rc);
    pulse_reset();
    check_idle_a("mid_reset");
    a_if.in_valid = 1'b1;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    chk("idle_ignores_valid", a_if.in_ready, 0);
    push_exp_a();
    start_a();
    load_a(0, NA, rc);
    wait_done_a();

    // Random frame, random gaps, start/valid noise during STREAM and DONE.
    pulse_reset();
    for (int i = 0; i < NA; i++) frame_a[i] = 5'($urandom_range(0, 31));
    push_exp_a();
    start_a();
    load_a(2, NA, rc);
    for (int i = 0; i < 10; i++) begin
      a_if.start = 1'($urandom_range(0, 1));
      a_if.in_valid = 1'($urandom_range(0, 1));
      a_if.in_pixel = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
    end
    a_if.start = 1'b0;
    a_if.in_valid = 1'b0;
    wait_done_a();
    for (int i = 0; i < 6; i++) begin
      a_if.start = 1'b1;
      a_if.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    a_if.start = 1'b0;
    a_if.in_valid = 1'b0;
    chk("done_after_noise", a_if.done, 1);
    chk("ready_after_noise", a_if.in_ready, 0);

    // 5x5 corner instance, all pixels at full scale.
    pulse_reset();
    b_if.start = 1'b1;
    @(posedge clk); #1;
    b_if.start = 1'b0;
    b_if.in_pixel = 5'd31;
    b_if.in_valid = 1'b1;
    k = 0;
    while (k < 25 && b_if.in_ready) begin
      @(posedge clk); #1;
      k++;
    end
    b_if.in_valid = 1'b0;
    chk("b_loaded", k, 25);
    k = 0;
    while (!b_if.done && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b_done", b_if.done, 1);
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
